r2fft_dma_reader: RTL and testbench

- Readout sequencer for the tri-buffer FFT core's DMA bus.
- On each FFT completion it walks the DMA address space once, issuing reads in natural or bit-reversed order.
- It re-times the returned samples through a credit-controlled FIFO and presents them as a valid/ready stream tagged with the frame's block-floating-point exponent.
- Sits between the FFT core wrapper (done/bfpexp/dmaact/dmaa/dmadr) and the downstream consumer.

---
 rtl/r2fft_dma_reader.sv | 147 ++++++++++++++
 tb/tb_r2fft_dma_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2fft_dma_reader.sv
// DMA readout sequencer for the FFT core: walks the frame's addresses once per done_i,
// re-times the returned samples through a credit-controlled FIFO onto a valid/ready stream.
module r2fft_dma_reader #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW     = 16,
  parameter int RD_LAT     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BITREV     = 0,
  localparam int FFT_N     = $clog2(FFT_LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_i,
  input  logic [7:0]        bfpexp_i,
  output logic              dmaact_o,
  output logic [FFT_N-1:0]  dmaa_o,
  input  logic [FFT_DW-1:0] dmadr_real_i,
  input  logic [FFT_DW-1:0] dmadr_imag_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [FFT_DW-1:0] m_real_o,
  output logic [FFT_DW-1:0] m_imag_o,
  output logic              m_last_o,
  output logic [7:0]        m_exp_o,
  output logic              busy_o,
  output logic              overrun_o
);

  // Stream handshake: a beat transfers on a rising edge where m_valid_o & m_ready_i;
  // m_valid_o never depends on m_ready_i and the beat is held stable until taken.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_nxt;

  logic [FFT_N-1:0]    cnt;
  logic [FFT_N-1:0]    out_cnt;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       fifo_count_nxt;
  logic [RD_LAT-1:0]   lat_sr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       rd_ptr_nxt;
  logic [2*FFT_DW-1:0] mem [FIFO_DEPTH];
  logic                push;
  logic                pop;
  logic                bypass;
  logic                issue;
  logic                credit_ok;

  function automatic logic [FFT_N-1:0] bit_rev(input logic [FFT_N-1:0] v);
    logic [FFT_N-1:0] r;
    for (int i = 0; i < FFT_N; i++) r[i] = v[FFT_N-1-i];
    return r;
  endfunction

  assign pop            = m_valid_o & m_ready_i;
  assign push           = lat_sr[RD_LAT-1];
  assign m_valid_o      = (fifo_count != '0);
  assign m_last_o       = m_valid_o & (out_cnt == FFT_N'(FFT_LENGTH - 1));
  assign busy_o         = (state != IDLE);
  // outstanding = FIFO occupancy + reads still in flight, so credit is DEPTH - outstanding
  assign credit_ok      = (outstanding < CW'(FIFO_DEPTH));
  assign rd_ptr_nxt     = rd_ptr + AW'(pop);
  assign fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
  // the entry being written becomes the head when nothing older survives this edge
  assign bypass         = push & (fifo_count == CW'(pop));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (done_i) state_nxt = READ;
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (cnt == FFT_N'(FFT_LENGTH - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop & m_last_o) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dmadr_real_i, dmadr_imag_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      lat_sr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      dmaact_o    <= 1'b0;
      dmaa_o      <= '0;
      m_real_o    <= '0;
      m_imag_o    <= '0;
      m_exp_o     <= '0;
      overrun_o   <= 1'b0;
    end else begin
      state     <= state_nxt;
      overrun_o <= done_i & busy_o;
      if (state == IDLE && done_i) begin
        m_exp_o <= bfpexp_i;
        cnt     <= '0;
      end
      dmaact_o <= issue;
      if (issue) begin
        dmaa_o <= (BITREV != 0) ? bit_rev(cnt) : cnt;
        cnt    <= cnt + 1'b1;
      end
      lat_sr[0] <= dmaact_o;
      for (int i = 1; i < RD_LAT; i++) lat_sr[i] <= lat_sr[i-1];
      outstanding <= outstanding + CW'(issue) - CW'(pop);
      fifo_count  <= fifo_count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      if (fifo_count_nxt != '0) begin
        if (bypass) begin
          m_real_o <= dmadr_real_i;
          m_imag_o <= dmadr_imag_i;
        end else begin
          {m_real_o, m_imag_o} <= mem[rd_ptr_nxt];
        end
      end
      if (pop) out_cnt <= (out_cnt == FFT_N'(FFT_LENGTH - 1)) ? '0 : out_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_r2fft_dma_reader.sv
// Bench for r2fft_dma_reader: natural-order and bit-reversed instances, a DMA RAM model
// with fixed read latency, and a queue scoreboard checked by an independent monitor.
module tb_r2fft_dma_reader;

  localparam int L     = 16;
  localparam int DW    = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int N     = 4;
  localparam int W     = 2*DW + 1 + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    bfpexp = '0;
  logic [1:0]    done_v = '0;
  logic [1:0]    ready_v = 2'b11;
  logic [DW-1:0] dr_re [2];
  logic [DW-1:0] dr_im [2];

  wire  [1:0]    dmaact, m_valid, m_last, busy, overrun;
  wire  [N-1:0]  dmaa [2];
  wire  [DW-1:0] m_re [2];
  wire  [DW-1:0] m_im [2];
  wire  [7:0]    m_exp [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    r2fft_dma_reader #(
      .FFT_LENGTH(L), .FFT_DW(DW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH), .BITREV(g)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .done_i(done_v[g]), .bfpexp_i(bfpexp),
      .dmaact_o(dmaact[g]), .dmaa_o(dmaa[g]),
      .dmadr_real_i(dr_re[g]), .dmadr_imag_i(dr_im[g]),
      .m_valid_o(m_valid[g]), .m_ready_i(ready_v[g]),
      .m_real_o(m_re[g]), .m_imag_o(m_im[g]), .m_last_o(m_last[g]),
      .m_exp_o(m_exp[g]), .busy_o(busy[g]), .overrun_o(overrun[g])
    );
  end

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int beats [2] = '{0, 0};
  logic track_en = 1'b0;
  int iss0 = 0, acc0 = 0, max_out0 = 0, last_cnt0 = 0;
  int br_tab [L] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic logic [DW-1:0] ram_re(input int a);
    return DW'(a*37 + 5);
  endfunction

  function automatic logic [DW-1:0] ram_im(input int a);
    return DW'(61440 + a*11);
  endfunction

  function automatic logic [63:0] outs(input int g);
    return 64'({dmaact[g], dmaa[g], m_valid[g], m_last[g], m_re[g], m_im[g], m_exp[g], busy[g], overrun[g]});
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // DMA RAM model: data for the address issued RD_LAT cycles earlier
  logic          p_act  [2][LAT+1];
  logic [N-1:0]  p_addr [2][LAT+1];
  initial begin
    for (int g = 0; g < 2; g++) begin
      dr_re[g] = '0;
      dr_im[g] = '0;
      for (int k = 0; k <= LAT; k++) begin
        p_act[g][k]  = 1'b0;
        p_addr[g][k] = '0;
      end
    end
    forever begin
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        for (int k = LAT; k > 0; k--) begin
          p_act[g][k]  = p_act[g][k-1];
          p_addr[g][k] = p_addr[g][k-1];
        end
        p_act[g][0]  = dmaact[g];
        p_addr[g][0] = dmaa[g];
        dr_re[g] = p_act[g][LAT] ? ram_re(int'(p_addr[g][LAT])) : 16'hDEAD;
        dr_im[g] = p_act[g][LAT] ? ram_im(int'(p_addr[g][LAT])) : 16'hBEEF;
      end
    end
  end

  // monitor: every accepted beat is popped from the matching queue and compared
  initial begin
    logic [W-1:0] beat, want;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int g = 0; g < 2; g++) begin
          if (g == 0 && track_en && dmaact[0]) iss0++;
          if (m_valid[g] && ready_v[g]) begin
            beat = {m_re[g], m_im[g], m_last[g], m_exp[g]};
            if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
              checks++;
              $display("FAIL unexpected_beat%0d: got %0h expected no beat", g, beat);
            end else begin
              want = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk($sformatf("beat%0d", g), 64'(beat), 64'(want));
            end
            beats[g]++;
            if (g == 0 && track_en) begin
              acc0++;
              if (m_last[0]) last_cnt0++;
            end
          end
          if (g == 0 && track_en && (iss0 - acc0) > max_out0) max_out0 = iss0 - acc0;
        end
      end
    end
  end

  task automatic push_frame(input int g, input logic [7:0] e);
    for (int k = 0; k < L; k++) begin
      int a;
      a = (g == 1) ? br_tab[k] : k;
      if (g == 0) exp_q0.push_back({ram_re(a), ram_im(a), (k == L-1), e});
      else        exp_q1.push_back({ram_re(a), ram_im(a), (k == L-1), e});
    end
  endtask

  task automatic pulse_done(input int g, input logic [7:0] e);
    bfpexp    = e;
    done_v[g] = 1'b1;
    @(posedge clk); #1;
    done_v[g] = 1'b0;
    bfpexp    = 8'h55;
  endtask

  task automatic start_frame(input int g, input logic [7:0] e);
    push_frame(g, e);
    pulse_done(g, e);
  endtask

  task automatic wait_idle(input int g, input bit rnd, input int budget);
    int n;
    n = 0;
    while (busy[g] && n < budget) begin
      if (rnd) ready_v[g] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    ready_v[g] = 1'b1;
    chk($sformatf("idle_timeout%0d", g), 64'(busy[g]), 64'(0));
    chk($sformatf("queue_drained%0d", g), 64'((g == 0) ? exp_q0.size() : exp_q1.size()), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] act_v, val_v, last_v, busy_v;
    int n_act, hold_bad, b0, n;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs0", outs(0), 64'(0));
    chk("reset_outputs1", outs(1), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame with cycle-exact timing, exponent -3
    push_frame(0, 8'hFD);
    pulse_done(0, 8'hFD);
    act_v = '0; val_v = '0; last_v = '0; busy_v = '0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      act_v[i]  = dmaact[0];
      val_v[i]  = m_valid[0];
      last_v[i] = m_last[0];
      busy_v[i] = busy[0];
      if (dmaact[0]) chk("addr_natural", 64'(dmaa[0]), 64'(i - 1));
      @(posedge clk); #1;
    end
    chk("dmaact_cycles", 64'(act_v), 64'h01FFFE);
    chk("m_valid_cycles", 64'(val_v), 64'h3FFFC0);
    chk("m_last_cycles", 64'(last_v), 64'h200000);
    chk("busy_cycles", 64'(busy_v), 64'h3FFFFF);
    wait_idle(0, 1'b0, 50);

    // bit-reversed instance
    start_frame(1, 8'h02);
    wait_idle(1, 1'b0, 100);

    // backpressure: ready low for cycles 3..40 after done
    push_frame(0, 8'h10);
    pulse_done(0, 8'h10);
    n_act = 0; hold_bad = 0;
    for (int i = 0; i < 46; i++) begin
      ready_v[0] = !(i >= 3 && i <= 40);
      @(negedge clk);
      if (i <= 40 && dmaact[0]) n_act++;
      if (i >= 6 && i <= 40 && !(m_valid[0] && m_re[0] == ram_re(0) && m_im[0] == ram_im(0)))
        hold_bad++;
      @(posedge clk); #1;
    end
    chk("issues_under_backpressure", 64'(n_act), 64'(DEPTH));
    chk("first_beat_held", 64'(hold_bad), 64'(0));
    wait_idle(0, 1'b0, 200);

    // 20 back-to-back frames with random ready
    iss0 = 0; acc0 = 0; max_out0 = 0; last_cnt0 = 0;
    track_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      start_frame(0, 8'(f*3 - 20));
      wait_idle(0, 1'b1, 400);
    end
    track_en = 1'b0;
    chk("last_count", 64'(last_cnt0), 64'(20));
    chk("outstanding_within_depth", 64'(max_out0 <= DEPTH), 64'(1));

    // done during READ
    b0 = beats[0];
    start_frame(0, 8'h21);
    repeat (3) begin @(posedge clk); #1; end
    pulse_done(0, 8'h7E);
    @(negedge clk);
    chk("overrun_pulse", 64'(overrun[0]), 64'(1));
    chk("exp_unchanged", 64'(m_exp[0]), 64'h21);
    @(posedge clk); #1;
    @(negedge clk);
    chk("overrun_single", 64'(overrun[0]), 64'(0));
    wait_idle(0, 1'b0, 100);
    chk("overrun_frame_beats", 64'(beats[0] - b0), 64'(L));
    repeat (25) begin @(posedge clk); #1; end
    chk("no_restart", 64'(busy[0]), 64'(0));

    // done in the cycle DRAIN exits is treated as busy
    start_frame(0, 8'h30);
    n = 0;
    while (!(m_valid[0] && m_last[0]) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_last_seen", 64'(m_last[0]), 64'(1));
    pulse_done(0, 8'h44);
    @(negedge clk);
    chk("overrun_at_drain_exit", 64'(overrun[0]), 64'(1));
    chk("idle_after_drain", 64'(busy[0]), 64'(0));
    repeat (10) begin @(posedge clk); #1; end
    chk("no_restart_drain", 64'(busy[0]), 64'(0));

    // reset while beat 5 is presented
    b0 = beats[0];
    start_frame(0, 8'h0A);
    n = 0;
    while ((beats[0] - b0) < 5 && n < 100) begin @(posedge clk); #1; n++; end
    chk("reached_beat5", 64'(beats[0] - b0), 64'(5));
    rst_n = 1'b0;
    exp_q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("outputs_after_reset", outs(0), 64'(0));
    repeat (20) begin @(posedge clk); #1; end
    chk("no_stale_beats", 64'(beats[0] - b0), 64'(5));
    b0 = beats[0];
    start_frame(0, 8'h0B);
    wait_idle(0, 1'b0, 100);
    chk("fresh_frame_beats", 64'(beats[0] - b0), 64'(L));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
